// File: rtl/led_blinker_pkg.sv
// Shared types for the multi-channel LED blinker.
// Modes, per-channel FSM states and the zero-clamp helper.
package led_blinker_pkg;

  typedef enum logic [1:0] {
    MODE_OFF,
    MODE_ON,
    MODE_BLINK,
    MODE_BURST
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SOLID,
    ST_ON,
    ST_OFF
  } state_t;

  // A zero phase length would never end; treat it as one tick.
  function automatic logic [31:0] clamp1(input logic [31:0] v);
    return (v == '0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/led_blinker_multi_channel.sv
// One LED channel: prescaler, phase counter, repeat counter, FSM.
// Ports: load + cfg fields in; registered led and done pulse out.
module led_channel
  import led_blinker_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 4,
  parameter int REP_W    = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  mode_t            mode,
  input  logic [CNT_W-1:0] on_len,
  input  logic [CNT_W-1:0] off_len,
  input  logic [REP_W-1:0] reps,
  output logic             led,
  output logic             done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  state_t           state;
  logic [PW-1:0]    pre;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] on_q;
  logic [CNT_W-1:0] off_q;
  logic [REP_W-1:0] rem;
  logic             burst;
  logic             tick;

  assign tick = (pre == PW'(PRESCALE - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      led   <= 1'b0;
      done  <= 1'b0;
      pre   <= '0;
      cnt   <= '0;
      on_q  <= '0;
      off_q <= '0;
      rem   <= '0;
      burst <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        pre   <= '0;
        cnt   <= '0;
        on_q  <= CNT_W'(clamp1(32'(on_len)));
        off_q <= CNT_W'(clamp1(32'(off_len)));
        rem   <= reps;
        burst <= (mode == MODE_BURST);
        unique case (mode)
          MODE_OFF: begin
            state <= ST_IDLE;
            led   <= 1'b0;
          end
          MODE_ON: begin
            state <= ST_SOLID;
            led   <= 1'b1;
          end
          MODE_BLINK: begin
            state <= ST_ON;
            led   <= 1'b1;
          end
          MODE_BURST: begin
            if (reps != '0) begin
              state <= ST_ON;
              led   <= 1'b1;
            end else begin
              state <= ST_IDLE;
              led   <= 1'b0;
              done  <= 1'b1;
            end
          end
        endcase
      end else if (state == ST_ON || state == ST_OFF) begin
        pre <= tick ? '0 : pre + 1'b1;
        if (tick) begin
          unique case (1'b1)
            (state == ST_ON): begin
              if (cnt == on_q - 1'b1) begin
                cnt   <= '0;
                state <= ST_OFF;
                led   <= 1'b0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            (state == ST_OFF): begin
              if (cnt == off_q - 1'b1) begin
                cnt <= '0;
                if (burst && rem == REP_W'(1)) begin
                  rem   <= '0;
                  state <= ST_IDLE;
                  done  <= 1'b1;
                end else begin
                  if (burst) rem <= rem - 1'b1;
                  state <= ST_ON;
                  led   <= 1'b1;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/led_blinker_multi.sv
// Multi-channel LED blinker with valid/ready runtime config.
// Ports: clock, reset_n, cfg_* request, led[], done[] pulses.
module led_blinker_multi
  import led_blinker_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int CNT_W    = 8,
  parameter int PRESCALE = 4,
  parameter int REP_W    = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_on,
  input  logic [CNT_W-1:0]    cfg_off,
  input  logic [REP_W-1:0]    cfg_reps,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] done
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic acc;

  assign acc = cfg_valid & cfg_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cfg_ready <= 1'b0;
    else          cfg_ready <= 1'b1;
  end

  // Out-of-range channel numbers match no instance and are dropped.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    led_channel #(
      .CNT_W   (CNT_W),
      .PRESCALE(PRESCALE),
      .REP_W   (REP_W)
    ) u_ch (
      .clock  (clock),
      .reset_n(reset_n),
      .load   (acc && (cfg_ch == CH_W'(i))),
      .mode   (mode_t'(cfg_mode)),
      .on_len (cfg_on),
      .off_len(cfg_off),
      .reps   (cfg_reps),
      .led    (led[i]),
      .done   (done[i])
    );
  end

endmodule

// File: doc/led_blinker_multi.md
Name: led_blinker_multi

Overview:
- Parametrised successor to the single free-running blinker: CHANNELS independent LED outputs, each programmed at runtime through a valid/ready config port.
- Per-channel modes: OFF, ON, continuous BLINK with independent on/off times, and BURST (N blinks, then stop and pulse done).
- Sits between board-level LED pins and a control FSM or UART command decoder.

Parameters:
- CHANNELS, 3: number of LED channels (1..16).
- CNT_W, 8: width of the on/off phase lengths, in ticks.
- PRESCALE, 4: clock cycles per tick (>=1).
- REP_W, 8: width of the burst repeat count.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  config can be accepted.
- cfg_ch  in  max(1,$clog2(CHANNELS))  target channel.
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- cfg_on  in  CNT_W  on-phase length in ticks.
- cfg_off  in  CNT_W  off-phase length in ticks.
- cfg_reps  in  REP_W  burst count (BURST only).
- led  out  CHANNELS  LED drive, registered.
- done  out  CHANNELS  one-cycle pulse when a burst completes.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - led=0, done=0, cfg_ready=0.
  - All channels IDLE; all counters and prescalers 0.
  - cfg_ready goes 1 at the first clock edge after reset_n rises, then stays 1.
- Accept: cfg_valid & cfg_ready at an edge.
  - cfg_ch >= CHANNELS: write silently ignored.
  - Otherwise the channel loads on/off/reps, and its prescaler and phase counter clear.
  - cfg_on=0 is clamped to 1; cfg_off=0 is clamped to 1.
- Per-channel prescaler and timing:
  - Each channel has its own prescaler counting 0..PRESCALE-1; tick when it equals PRESCALE-1.
  - Timing is exact: an on phase lasts on*PRESCALE cycles; an off phase lasts off*PRESCALE cycles.
- Per-channel states: IDLE (led 0), SOLID (led 1), ON_PH (led 1), OFF_PH (led 0).
- Transitions on accept (led takes the new value at the accepting edge):
  - OFF -> IDLE.
  - ON -> SOLID.
  - BLINK -> ON_PH.
  - BURST with reps>0 -> ON_PH, remaining=reps.
  - BURST with reps=0 -> IDLE, with done pulsed at that edge.
- ON_PH: phase counter increments on tick. On the tick where counter==on-1: counter=0, go to OFF_PH.
- OFF_PH: on the tick where counter==off-1: counter=0.
  - BLINK: -> ON_PH.
  - BURST: remaining-1. If the result is 0 -> IDLE with done=1 for exactly one cycle; else -> ON_PH.
- Simultaneous events:
  - A config accept to a channel overrides any phase transition on that channel in the same cycle.
  - No done pulse is emitted for a burst that is aborted or reprogrammed.
- Channel isolation: a config write never disturbs other channels' counters or prescalers.
- Reset mid-operation: the state is abandoned; no done after release.

Decomposition:
- Package led_blinker_pkg:
  - mode_t enum {MODE_OFF, MODE_ON, MODE_BLINK, MODE_BURST}.
  - state_t enum {ST_IDLE, ST_SOLID, ST_ON, ST_OFF}.
  - Zero-clamp helper function.
- Sub-module led_channel (one per channel, generate loop):
  - Owns its prescaler, phase counter, repeat counter and FSM.
  - Inputs: load strobe plus config fields. Outputs: led bit and done bit.
- Top level: cfg_ready register, channel decode/range check, output concatenation.

Test Plan (defaults: CHANNELS=3, PRESCALE=4, CNT_W=8):
- Reset: hold reset_n=0 for 3 cycles -> led=000, done=000, cfg_ready=0; release -> cfg_ready=1 after one edge.
- BLINK: ch0 on=2, off=3 -> led[0]=1 for 8 cycles, 0 for 12 cycles, repeating with a 20-cycle period; led[2:1]=00 throughout.
- BURST: ch1 on=1, off=1, reps=3 -> three 4-cycle highs separated by 4-cycle lows; done[1]=1 for one cycle exactly 24 cycles after accept; led[1] then stays 0.
- Edge configs:
  - ch2 BLINK on=0, off=0 -> toggles every 4 cycles (clamp).
  - cfg_ch=3 -> no channel changes.
  - BURST reps=0 -> done pulse at the accept edge, led stays 0.
- Abort and reprogram: mid-burst on ch1, write OFF -> led[1]=0 at the accept edge, no done ever. Restart the burst, then pulse reset_n low mid-burst -> all led=0, no done after release.
- Independence: run ch0 BLINK, reprogram ch1 every 5 cycles -> ch0 waveform unchanged, still exact 20-cycle period.
